// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package loader_pkg;

  localparam int DEFAULT_MEM_DEPTH = 1024;
  localparam int DEFAULT_ADDR_W    = 10;

  typedef logic [15:0] count_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Modulo-256 running sum used by the optional checksum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: packs four bytes little-endian into a 32-bit word; first byte lands in bits 7:0.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Byte counter and shift register for the three earlier bytes of a word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_clr) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end else begin
      r_cnt   <= r_cnt;
      r_shift <= r_shift;
    end
  end

  // The fourth byte is still on the input, so the full word is presented combinationally.
  assign o_word       = {i_byte, r_shift};
  assign o_word_ready = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction-memory loader; define LOADER_CHECKSUM_EN to add a trailing checksum byte.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_Wdata,
  output logic              Core_Rst,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(BASE_ADDR % MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(MEM_DEPTH - 1);

  state_t            r_state, w_next;
  logic              r_rx_ready, r_mem_we, r_core_rst, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_mem_addr, r_addr;
  logic [31:0]       r_mem_wdata;
  logic [7:0]        r_len_lo;
  logic              r_len_phase;
  count_t            r_count, r_index;
  count_t            w_len;
  logic              w_accept, w_last, w_word_ready, w_enter_len;
  logic [31:0]       w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  assign w_accept    = Rx_Valid && r_rx_ready;
  assign w_len       = {Rx_Data, r_len_lo};
  assign w_last      = (r_index + 16'd1) == r_count;
  assign w_enter_len = (w_next == S_LEN) && (r_state != S_LEN);

  byte_packer u_packer (
    .i_clk        (Clk),
    .i_rst        (Rst),
    .i_clr        (r_state != S_DATA),
    .i_valid      (w_accept && (r_state == S_DATA)),
    .i_byte       (Rx_Data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; Start is only honoured outside an active session.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) w_next = S_LEN;
        else       w_next = r_state;
      end
      S_LEN: begin
        if (w_accept && r_len_phase) begin
          if ((w_len == 16'd0) || (32'(w_len) > MEM_DEPTH)) w_next = S_ERR;
          else                                              w_next = S_DATA;
        end else begin
          w_next = S_LEN;
        end
      end
      S_DATA: begin
        if (w_word_ready) w_next = S_WRITE;
        else              w_next = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_WRITE: begin
        if (w_last) w_next = S_CHK;
        else        w_next = S_DATA;
      end
      S_CHK: begin
        if (w_accept) w_next = (Rx_Data == r_sum) ? S_DONE : S_ERR;
        else          w_next = S_CHK;
      end
`else
      S_WRITE: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_DATA;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_core_rst  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_rx_ready <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CHK);
      r_busy     <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_WRITE) || (w_next == S_CHK);
      r_mem_we   <= (w_next == S_WRITE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERR);
      r_core_rst <= (w_next == S_DONE);
      if (r_state == S_DATA && w_word_ready) begin
        r_mem_wdata <= w_word;
        r_mem_addr  <= r_addr;
      end else begin
        r_mem_wdata <= r_mem_wdata;
        r_mem_addr  <= r_mem_addr;
      end
    end
  end

  // Session counters: length capture, word index and wrapping write address.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_len_lo    <= 8'd0;
      r_len_phase <= 1'b0;
      r_count     <= 16'd0;
      r_index     <= 16'd0;
      r_addr      <= '0;
    end else if (w_enter_len) begin
      r_len_phase <= 1'b0;
      r_index     <= 16'd0;
      r_addr      <= ADDR_START;
    end else if (r_state == S_LEN && w_accept) begin
      if (r_len_phase) begin
        r_count     <= w_len;
        r_len_phase <= 1'b0;
      end else begin
        r_len_lo    <= Rx_Data;
        r_len_phase <= 1'b1;
      end
    end else if (r_state == S_WRITE) begin
      r_index <= r_index + 16'd1;
      r_addr  <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
    end else begin
      r_index <= r_index;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of data bytes, cleared at the start of each session.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sum <= 8'd0;
    end else if (w_enter_len) begin
      r_sum <= 8'd0;
    end else if (r_state == S_DATA && w_accept) begin
      r_sum <= sum8(r_sum, Rx_Data);
    end else begin
      r_sum <= r_sum;
    end
  end
`endif

  assign Rx_Ready  = r_rx_ready;
  assign Mem_We    = r_mem_we;
  assign Mem_Addr  = r_mem_addr;
  assign Mem_Wdata = r_mem_wdata;
  assign Core_Rst  = r_core_rst;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Err       = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued, a monitor checks each Mem_We.
module tb_instr_mem_loader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Rx_Data = 8'd0;
  logic        Rx_Valid = 1'b0;
  logic        Rx_Ready, Mem_We, Core_Rst, Busy, Done, Err;
  logic [9:0]  Mem_Addr;
  logic [31:0] Mem_Wdata;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  instr_mem_loader dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
    .Rx_Ready(Rx_Ready), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Core_Rst(Core_Rst), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge Clk) begin
    if (!Rst && Mem_We) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %03h data %08h, expected no write", Mem_Addr, Mem_Wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(Mem_Addr), 32'(w.addr));
        check("write_data", Mem_Wdata, w.data);
        check("rx_ready_in_write", 32'(Rx_Ready), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge Clk);
    @(negedge Clk);
    Rx_Valid = 1'b1;
    Rx_Data  = b;
    for (k = 0; k < 200; k++) begin
      if (Rx_Ready) break;
      @(negedge Clk);
    end
    if (k == 200) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_timeout: byte %02h not accepted, expected acceptance", b);
    end
    @(posedge Clk);
    #1 Rx_Valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_status(input string name, input logic e_done, input logic e_err,
                             input logic e_core, input logic e_busy);
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (Done || Err) break;
    end
    check({name, "_done"}, 32'(Done), 32'(e_done));
    check({name, "_err"}, 32'(Err), 32'(e_err));
    check({name, "_core_rst"}, 32'(Core_Rst), 32'(e_core));
    check({name, "_busy"}, 32'(Busy), 32'(e_busy));
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic two_word_session(input int gap, input logic poke_start);
    logic [7:0] bytes [0:9];
    bytes = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    exp_q.push_back('{addr: 10'd0, data: 32'h00500093});
    exp_q.push_back('{addr: 10'd1, data: 32'h00A00113});
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (poke_start && i == 4) pulse_start();
      send_byte(bytes[i], gap);
    end
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("reset_outputs", {20'd0, Rx_Ready, Mem_We, Busy, Done, Err, Core_Rst, 6'd0}, 32'd0);
    check("reset_addr_data", 32'(Mem_Addr) | Mem_Wdata, 32'd0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_rx_ready", 32'(Rx_Ready), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back('{addr: 10'd0, data: 32'h00500093});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'hE3, 0);
    wait_status("chk_good", 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{addr: 10'd0, data: 32'h00500093});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'hE4, 0);
    wait_status("chk_bad", 1'b0, 1'b1, 1'b0, 1'b0);
`else
    // Two words back to back.
    two_word_session(0, 1'b0);
    wait_status("two_words", 1'b1, 1'b0, 1'b1, 1'b0);

    // Zero length is rejected; Start from DONE clears status first.
    pulse_start();
    check("restart_status", {29'd0, Done, Err, Core_Rst}, 32'd0);
    check("restart_busy", 32'(Busy), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_status("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);

    // One word past the memory depth is rejected.
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    wait_status("len_1025", 1'b0, 1'b1, 1'b0, 1'b0);

    // Sparse Rx_Valid plus a Start while busy must give identical writes.
    two_word_session(2, 1'b1);
    wait_status("sparse", 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // Exactly MEM_DEPTH words is legal: the loader enters DATA instead of ERR.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    @(negedge Clk);
    check("len_1024_busy", {30'd0, Busy, Err}, 32'd2);

    // Reset mid-word: outputs clear at once and nothing is written afterwards.
    pulse_start();
    check("len_1024_ignores_start", 32'(Busy), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("abort_outputs", {26'd0, Rx_Ready, Mem_We, Busy, Done, Err, Core_Rst}, 32'd0);
    check("abort_addr_data", 32'(Mem_Addr) | Mem_Wdata, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h00, 0);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("mid_rst_outputs", {26'd0, Rx_Ready, Mem_We, Busy, Done, Err, Core_Rst}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    Rx_Valid = 1'b1;
    Rx_Data  = 8'h50;
    repeat (12) @(negedge Clk);
    Rx_Valid = 1'b0;
    check("post_rst_idle", {28'd0, Rx_Ready, Busy, Done, Err}, 32'd0);
    check("post_rst_no_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
